seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised successor to the fixed-pattern 3-bit sequence detector.
- Detects a runtime-programmable serial bit pattern of WIDTH bits on input a, sampled only on cycles where en is high. en is typically the debounced strobe from the board top level.
- Supports overlapping and non-overlapping detection, a registered one-cycle match pulse, and a saturating match counter.
- Sits between the input debounce logic and the LED/status outputs in the lab top level.

Parameters:
- WIDTH, 3, pattern length in bits (legal range 2..16).
- COUNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Logic 0 resets the block.
- en  input  1  sample strobe. a is consumed only on cycles with en=1.
- a  input  1  serial data bit.
- load  input  1  capture pattern_in into the pattern register and restart detection.
- pattern_in  input  WIDTH  new pattern. Bit WIDTH-1 is the first bit expected, bit 0 the last.
- overlap  input  1  1 = overlapping matches allowed; 0 = bits of a match are not reused.
- clear_count  input  1  synchronous clear of match_count.
- fill  output  $clog2(WIDTH+1)  number of valid history bits, saturating at WIDTH.
- match  output  1  one-cycle pulse, registered.
- match_count  output  COUNT_W  number of matches since reset or clear_count, saturating.

Behaviour:
Reset (reset=0, asynchronous):
- history = 0, fill = 0, match = 0, match_count = 0.
- pattern_reg resets to {1'b0, {WIDTH-1{1'b1}}}, i.e. 3'b011 at the default WIDTH.
- Reset asserted mid-sequence discards all partial progress.

Sample cycle (en=1, load=0):
- history <= {history[WIDTH-2:0], a}.
- fill <= min(fill+1, WIDTH).

Hit condition, evaluated on the post-shift values:
- hit = (fill_next == WIDTH) && (history_next == pattern_reg).
- On hit, match is 1 in the cycle after the sampling edge and 0 otherwise. Latency is 1 clk from the sampling edge.
- A hit with overlap=0 forces fill <= 0; history is still updated. The next match needs WIDTH fresh samples.
- A hit with overlap=1 leaves fill at WIDTH, so a match can recur on any later sample.

Non-sample cycle (en=0):
- history and fill hold.
- match <= 0. The match pulse is never stretched by en being low.

load=1:
- pattern_reg <= pattern_in, history <= 0, fill <= 0, match <= 0.
- load has priority over en in the same cycle; that sample is discarded.
- match_count is unaffected by load.

match_count:
- Increments by 1 on the same edge that sets match.
- Saturates at 2^COUNT_W - 1; no wrap.
- clear_count=1 sets it to 0. If a hit occurs in the same cycle, clear wins and the count is 0.
- match still pulses in that case.

Other rules:
- The internal state is the fill counter plus the history register; there is no hidden FSM.
- An all-zero or all-one pattern is legal.
- All outputs are driven directly from flops.

Test Plan:
1. Reset, default pattern 011, overlap=1, en every cycle, a = 0,1,1,0,1,1 -> match pulses 1 cycle after the 3rd and 6th samples; match_count = 2.
2. load pattern_in = 3'b111, overlap=1, a = 1,1,1,1,1 -> matches after samples 3, 4, 5; count = 3. Repeat with overlap=0 -> matches after sample 3 only. A 6th 1 gives a match after sample 6.
3. en toggled 1-of-4 cycles with a pattern 0,1,1 -> exactly one match pulse, 1 cycle wide. history and fill hold between strobes; fill reads 0,1,2,3 on successive strobes.
4. COUNT_W=2, 5 matches -> match_count saturates at 3. Then clear_count coincident with a hit -> count reads 0 and match = 1.
5. Assert reset low asynchronously after 2 of 3 pattern bits; release, then send the last bit alone -> no match; fill = 1.
6. load asserted with en=1 in the same cycle -> that sample is ignored; fill = 0; the new pattern is active from the next sample.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable WIDTH-bit pattern, optional overlap,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
   parameter int WIDTH   = 3,
   parameter int COUNT_W = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          a,
   input  logic                          load,
   input  logic [WIDTH-1:0]              pattern_in,
   input  logic                          overlap,
   input  logic                          clear_count,
   output logic [$clog2(WIDTH+1)-1:0]    fill,
   output logic                          match,
   output logic [COUNT_W-1:0]            match_count
);

   localparam int                 FILL_W      = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0]  FILL_MAX    = FILL_W'(WIDTH);
   localparam logic [WIDTH-1:0]   PATTERN_RST = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};

   logic [WIDTH-1:0]   r_pattern;
   logic [WIDTH-1:0]   r_history;
   logic [FILL_W-1:0]  r_fill;
   logic               r_match;
   logic [COUNT_W-1:0] r_count;

   logic [WIDTH-1:0]   w_history_next;
   logic [FILL_W-1:0]  w_fill_next;
   logic               w_sample;
   logic               w_hit;

   // A load cycle discards the sample, so only en-without-load can produce a hit.
   assign w_sample       = en && !load;
   assign w_history_next = {r_history[WIDTH-2:0], a};
   assign w_fill_next    = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
   assign w_hit          = w_sample && (w_fill_next == FILL_MAX) && (w_history_next == r_pattern);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pattern <= PATTERN_RST;
         r_history <= '0;
         r_fill    <= '0;
         r_match   <= 1'b0;
         r_count   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop reading pre-edge values, so block order is irrelevant.
         r_match <= w_hit;

         if (load) begin
            r_pattern <= pattern_in;
            r_history <= '0;
            r_fill    <= '0;
         end else if (en) begin
            r_history <= w_history_next;
            r_fill    <= (w_hit && !overlap) ? '0 : w_fill_next;
         end

         if (clear_count) begin
            r_count <= '0;
         end else if (w_hit && (r_count != COUNT_MAX)) begin
            r_count <= r_count + COUNT_W'(1);
         end
      end
   end

   assign fill        = r_fill;
   assign match       = r_match;
   assign match_count = r_count;

endmodule
